// File: rtl/dsp_post_pkg.sv
// Shared constants and select encodings for the DSP post-adder / P stage.
package dsp_post_pkg;

    localparam int unsigned P_W     = 48;
    localparam int unsigned M_W     = 36;
    localparam int unsigned OPM_W   = 8;
    localparam int unsigned SEL_W   = 2;

    // Field positions inside OPMODE
    localparam int unsigned X_SEL   = 0;
    localparam int unsigned Z_SEL   = 2;
    localparam int unsigned CIN_BIT = 5;
    localparam int unsigned SUB_BIT = 7;

    typedef enum logic [SEL_W-1:0] {X_ZERO, X_M, X_P, X_DAB} x_sel_e;
    typedef enum logic [SEL_W-1:0] {Z_ZERO, Z_PCIN, Z_P, Z_C} z_sel_e;

    localparam logic [P_W-1:0] SAT_POS = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] SAT_NEG = {1'b1, {(P_W-1){1'b0}}};

    // True when either operand mux feeds P back into the adder
    function automatic logic sel_reads_p(input logic [OPM_W-1:0] opm);
        return (x_sel_e'(opm[X_SEL +: SEL_W]) == X_P) ||
               (z_sel_e'(opm[Z_SEL +: SEL_W]) == Z_P);
    endfunction

endpackage

// File: rtl/dsp_post_adder_p_stage_pipe_reg.sv
// Optional pipeline register: sync reset, clock enable, or pure wire when REG=0.
module dsp_pipe_reg #(
    parameter bit          REG   = 1'b1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (REG) begin : g_reg
        logic [WIDTH-1:0] q_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q_q <= '0;
            end else if (ce) begin
                q_q <= d;
            end
        end

        assign q = q_q;
    end else begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, ce};
        assign q = d;
    end

endmodule

// File: rtl/dsp_post_adder_p_stage.sv
// DSP48A1-style output stage: X/Z muxes, post-adder/subtracter, P and CARRYOUT registers.
// Build option DSP_POST_SAT_EN: clamp P on signed 48-bit overflow instead of wrapping.
module dsp_post_adder_p_stage
    import dsp_post_pkg::*;
#(
    parameter bit          PREG        = 1'b1,
    parameter bit          CARRYOUTREG = 1'b1,
    parameter bit          CARRYINREG  = 1'b1,
    parameter bit          OPMODEREG   = 1'b1,
    parameter string       CARRYINSEL  = "OPMODE5",
    parameter int unsigned WIDTH       = P_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cep,
    input  logic             cecarryin,
    input  logic             ceopmode,
    input  logic [OPM_W-1:0] opmode,
    input  logic [M_W-1:0]   m,
    input  logic [P_W-1:0]   dab,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] pcin,
    input  logic             carryin,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] pcout,
    output logic             carryout,
    output logic             carryoutf
);

    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

    logic [OPM_W-1:0] opm;
    logic             cyi_d;
    logic             cyi;
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] z_op;
    logic [WIDTH:0]   x_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] p_q;
    logic             co_q;

    dsp_pipe_reg #(.REG(OPMODEREG), .WIDTH(OPM_W)) u_opm_reg (
        .clk (clk), .rst (rst), .ce (ceopmode), .d (opmode), .q (opm)
    );

    assign cyi_d = CIN_FROM_PORT ? carryin : opm[CIN_BIT];

    dsp_pipe_reg #(.REG(CARRYINREG), .WIDTH(1)) u_cyi_reg (
        .clk (clk), .rst (rst), .ce (cecarryin), .d (cyi_d), .q (cyi)
    );

    always_comb begin
        x_op = '0;
        z_op = '0;
        case (x_sel_e'(opm[X_SEL +: SEL_W]))
            X_ZERO:  x_op = '0;
            X_M:     x_op = WIDTH'(m);
            X_P:     x_op = p_q;
            X_DAB:   x_op = WIDTH'(dab);
            default: x_op = '0;
        endcase
        case (z_sel_e'(opm[Z_SEL +: SEL_W]))
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = pcin;
            Z_P:     z_op = p_q;
            Z_C:     z_op = c;
            default: z_op = '0;
        endcase
    end

    // Carry-in folds into X so subtract yields Z - (X + cyi); bit WIDTH is carry/borrow
    always_comb begin
        x_cin = {1'b0, x_op} + (WIDTH+1)'(cyi);
        sum   = opm[SUB_BIT] ? ({1'b0, z_op} - x_cin) : ({1'b0, z_op} + x_cin);
    end

`ifdef DSP_POST_SAT_EN
    logic [WIDTH+1:0] x_s;
    logic [WIDTH+1:0] z_s;
    logic [WIDTH+1:0] s_wide;

    // Two guard bits: overflow whenever the top three bits disagree
    always_comb begin
        x_s    = {{2{x_op[WIDTH-1]}}, x_op};
        z_s    = {{2{z_op[WIDTH-1]}}, z_op};
        s_wide = opm[SUB_BIT] ? (z_s - (x_s + (WIDTH+2)'(cyi)))
                              : (z_s + x_s + (WIDTH+2)'(cyi));
        p_d    = s_wide[WIDTH-1:0];
        if ((s_wide[WIDTH+1:WIDTH-1] != 3'b000) && (s_wide[WIDTH+1:WIDTH-1] != 3'b111)) begin
            p_d = s_wide[WIDTH+1] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
        end
    end
`else
    assign p_d = sum[WIDTH-1:0];
`endif

    dsp_pipe_reg #(.REG(PREG), .WIDTH(WIDTH)) u_p_reg (
        .clk (clk), .rst (rst), .ce (cep), .d (p_d), .q (p_q)
    );

    dsp_pipe_reg #(.REG(CARRYOUTREG), .WIDTH(1)) u_co_reg (
        .clk (clk), .rst (rst), .ce (cecarryin), .d (sum[WIDTH]), .q (co_q)
    );

    assign p         = p_q;
    assign pcout     = p_q;
    assign carryout  = co_q;
    assign carryoutf = co_q;

    logic unused_in;
    assign unused_in = &{1'b0, opm[4], opm[6], opm[CIN_BIT], carryin};

    // Selecting P as an operand without the P register closes a combinational loop
    always_ff @(posedge clk) begin
        if (!rst && !PREG) begin
            assert (!sel_reads_p(opm)) else $error("P feedback selected with PREG=0");
        end
    end

endmodule

// File: tb/tb_dsp_post_adder_p_stage.sv
// Self-checking bench for dsp_post_adder_p_stage (default parameters).
// Honours DSP_POST_SAT_EN when the build defines it.
module tb_dsp_post_adder_p_stage;

    logic        clk = 1'b0;
    logic        rst, cep, cecarryin, ceopmode, carryin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    int tests = 0;
    int fails = 0;

    // Reference model state (values visible after the last edge)
    logic [7:0]  mo   = '0;
    logic        mcyi = 1'b0;
    logic [47:0] mp   = '0;
    logic        mco  = 1'b0;

    always #5 clk = ~clk;

    dsp_post_adder_p_stage dut (
        .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .ceopmode(ceopmode),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
    );

    // Returns {carry, P input} from plain 64-bit arithmetic on the selected operands
    function automatic logic [48:0] post_add(input logic [7:0] o, input logic ci,
                                             input logic [47:0] pv);
        longint unsigned xv, zv, r;
        longint          sx, sz, cs, s;
        logic [47:0]     pres;
        case (o[1:0])
            2'd0: xv = 64'd0;
            2'd1: xv = 64'(m);
            2'd2: xv = 64'(pv);
            default: xv = 64'(dab);
        endcase
        case (o[3:2])
            2'd0: zv = 64'd0;
            2'd1: zv = 64'(pcin);
            2'd2: zv = 64'(pv);
            default: zv = 64'(c);
        endcase
        r    = o[7] ? (zv - (xv + 64'(ci))) : (zv + xv + 64'(ci));
        pres = r[47:0];
        cs   = ci ? 64'sd1 : 64'sd0;
        sx   = xv[47] ? ($signed(xv) - 64'sh1_0000_0000_0000) : $signed(xv);
        sz   = zv[47] ? ($signed(zv) - 64'sh1_0000_0000_0000) : $signed(zv);
        s    = o[7] ? (sz - (sx + cs)) : (sz + sx + cs);
`ifdef DSP_POST_SAT_EN
        if (s > 64'sh7FFF_FFFF_FFFF)       pres = 48'h7FFF_FFFF_FFFF;
        else if (s < -64'sh8000_0000_0000) pres = 48'h8000_0000_0000;
`else
        if (s == 64'sd0) pres = r[47:0];
`endif
        return {r[48], pres};
    endfunction

    // Advance one clock: model and DUT both see the inputs held before the edge
    task automatic tick();
        logic [7:0]  mo_n;
        logic        mcyi_n, mco_n;
        logic [47:0] mp_n;
        logic [48:0] r;
        r = post_add(mo, mcyi, mp);
        if (rst) begin
            mo_n = '0; mcyi_n = 1'b0; mp_n = '0; mco_n = 1'b0;
        end else begin
            mo_n   = ceopmode  ? opmode : mo;
            mcyi_n = cecarryin ? mo[5]  : mcyi;
            mp_n   = cep       ? r[47:0] : mp;
            mco_n  = cecarryin ? r[48]  : mco;
        end
        @(posedge clk);
        mo = mo_n; mcyi = mcyi_n; mp = mp_n; mco = mco_n;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cep = 1'b1; cecarryin = 1'b1; ceopmode = 1'b1; carryin = 1'b0;
        opmode = 8'h0D; m = 36'd7; dab = '1; c = 48'd9; pcin = 48'd4;
        tick(); tick();
        tests++; if (p !== 48'd0) begin $display("FAIL reset_p got=%h exp=0", p); fails++; end
        tests++; if (pcout !== 48'd0) begin $display("FAIL reset_pcout got=%h exp=0", pcout); fails++; end
        tests++; if (carryout !== 1'b0 || carryoutf !== 1'b0) begin
            $display("FAIL reset_carry got=%b/%b exp=0/0", carryout, carryoutf); fails++; end
        rst = 1'b0;
    endtask

    task automatic test_add_c();
        opmode = 8'h0D; m = 36'd5; c = 48'd100; dab = '0; pcin = '0;
        tick(); tick();
        tests++; if (p !== 48'd105) begin $display("FAIL add_c_p got=%0d exp=105", p); fails++; end
        tests++; if (pcout !== 48'd105) begin $display("FAIL add_c_pcout got=%0d exp=105", pcout); fails++; end
        tests++; if (carryout !== 1'b0) begin $display("FAIL add_c_co got=%b exp=0", carryout); fails++; end
        tests++; if (p !== mp) begin $display("FAIL add_c_model got=%h exp=%h", p, mp); fails++; end
    endtask

    task automatic test_accumulate();
        rst = 1'b1; opmode = 8'h09; m = 36'd3; tick();
        rst = 1'b0; cep = 1'b0; tick();
        cep = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++; if (p !== 48'(3 * k)) begin
                $display("FAIL accum_step%0d got=%0d exp=%0d", k, p, 3 * k); fails++; end
        end
        cep = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m = 36'($urandom); c = 48'($urandom);
            tick();
            tests++; if (p !== 48'd12 || pcout !== 48'd12) begin
                $display("FAIL accum_hold got=%0d/%0d exp=12", p, pcout); fails++; end
        end
        cep = 1'b1; m = 36'd3;
    endtask

    task automatic test_reset_mid();
        logic [47:0] exp_seq [4];
        exp_seq = '{48'd0, 48'd0, 48'd3, 48'd6};
        rst = 1'b1; opmode = 8'h09; m = 36'd3; tick();
        rst = 1'b0; cep = 1'b0; tick();
        cep = 1'b1; tick(); tick();
        rst = 1'b1; tick();
        tests++; if (p !== 48'd0) begin $display("FAIL rst_mid_clear got=%0d exp=0", p); fails++; end
        rst = 1'b0;
        // opmode register was cleared too, so one cycle of X=Z=0 precedes the restart
        for (int k = 1; k < 4; k++) begin
            tick();
            tests++; if (p !== exp_seq[k]) begin
                $display("FAIL rst_mid_resume%0d got=%0d exp=%0d", k, p, exp_seq[k]); fails++; end
        end
    endtask

    task automatic test_subtract();
        opmode = 8'h8D; c = 48'd10; m = 36'd12;
        tick(); tick();
        tests++; if (p !== 48'hFFFF_FFFF_FFFE) begin
            $display("FAIL sub_p got=%h exp=fffffffffffe", p); fails++; end
        tests++; if (carryout !== 1'b1 || carryoutf !== 1'b1) begin
            $display("FAIL sub_borrow got=%b/%b exp=1/1", carryout, carryoutf); fails++; end
    endtask

    task automatic test_carryin();
        opmode = 8'h2F; dab = 48'hFFFF_FFFF_FFFF; c = 48'd0;
        tick(); tick(); tick();
        tests++; if (p !== 48'd0) begin $display("FAIL cin_p got=%h exp=0", p); fails++; end
        tests++; if (carryout !== 1'b1) begin $display("FAIL cin_co got=%b exp=1", carryout); fails++; end
    endtask

    task automatic test_saturation();
        logic [47:0] exp_p;
`ifdef DSP_POST_SAT_EN
        exp_p = 48'h7FFF_FFFF_FFFF;
`else
        exp_p = 48'h8000_0000_0000;
`endif
        opmode = 8'h0F; c = 48'h7FFF_FFFF_FFFF; dab = 48'd1;
        tick(); tick(); tick();
        tests++; if (p !== exp_p) begin $display("FAIL sat_p got=%h exp=%h", p, exp_p); fails++; end
        tests++; if (carryout !== 1'b0) begin $display("FAIL sat_co got=%b exp=0", carryout); fails++; end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            cep       = ($urandom_range(0, 7) != 0);
            cecarryin = ($urandom_range(0, 7) != 0);
            ceopmode  = ($urandom_range(0, 3) != 0);
            opmode    = 8'($urandom);
            carryin   = 1'($urandom);
            m         = {4'($urandom), 32'($urandom)};
            dab       = {16'($urandom), 32'($urandom)};
            c         = {16'($urandom), 32'($urandom)};
            pcin      = {16'($urandom), 32'($urandom)};
            tick();
            tests++; if (p !== mp) begin
                $display("FAIL rand_p cyc=%0d got=%h exp=%h", i, p, mp); fails++; end
            tests++; if (pcout !== mp) begin
                $display("FAIL rand_pcout cyc=%0d got=%h exp=%h", i, pcout, mp); fails++; end
            tests++; if (carryout !== mco) begin
                $display("FAIL rand_co cyc=%0d got=%b exp=%b", i, carryout, mco); fails++; end
            tests++; if (carryoutf !== mco) begin
                $display("FAIL rand_cof cyc=%0d got=%b exp=%b", i, carryoutf, mco); fails++; end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_c();
        test_accumulate();
        test_reset_mid();
        test_subtract();
        test_carryin();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dsp_post_adder_p_stage.md
Name: dsp_post_adder_p_stage

Overview:
Output end of the DSP48A1-style slice: post-adder/subtracter, X/Z operand muxes, carry-in select, P accumulator register and CARRYOUT register.
Consumes the multiplier product M and the D:A:B concatenation produced by the input register stages. Drives P, PCOUT and CARRYOUT to the fabric and the cascade.
Real sequential behaviour: accumulation through P feedback, optional OPMODE/carry-in pipelining.

Parameters:
PREG, 1, 1 = P output registered; 0 = combinational.
CARRYOUTREG, 1, 1 = CARRYOUT registered.
CARRYINREG, 1, 1 = carry-in (CYI) registered.
OPMODEREG, 1, 1 = OPMODE registered.
CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses opmode[5]; "CARRYIN" uses the carryin port.
WIDTH, 48, P/C/PCIN width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high; clears P, CARRYOUT, CYI and OPMODE registers
cep  in  1  clock enable for the P register
cecarryin  in  1  clock enable for the CYI and CARRYOUT registers
ceopmode  in  1  clock enable for the OPMODE register
opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] 1 = subtract
m  in  36  multiplier product
dab  in  48  {D[11:0],A[17:0],B[17:0]}
c  in  48  C operand
pcin  in  48  cascade input
carryin  in  1  fabric carry-in
p  out  48  result
pcout  out  48  equals p
carryout  out  1  post-adder carry/borrow
carryoutf  out  1  equals carryout

Behaviour:
- Every register: synchronous reset to 0 when rst=1; rst has priority over its ce. When ce=0 the register holds its value.
- Each register is bypassed combinationally when its parameter is 0.
- opm: OPMODE after the optional register. cyi: carry-in after the optional register.
- X mux on opm[1:0]:
  - 0 -> 0
  - 1 -> {12'b0, m}
  - 2 -> p
  - 3 -> dab
- Z mux on opm[3:2]:
  - 0 -> 0
  - 1 -> pcin
  - 2 -> p
  - 3 -> c
- Post-adder, 49-bit unsigned:
  - opm[7]=0: r = Z + X + cyi
  - opm[7]=1: r = Z - (X + cyi)
  - P input = r[47:0] (wraps mod 2^48); carry input = r[48].
- Latency from operands to p:
  - PREG=1: 1 cycle.
  - OPMODEREG=1 adds 1 cycle for opmode only; operands are not delayed.
- Accumulate: X=m with Z=p (opmode 0x09) adds m into p every cycle where cep=1.
- P feedback (X or Z = p) with PREG=0 is illegal. It forms a combinational loop. A simulation assertion must fire on it.
- Reset mid-accumulation: p=0 on the next edge. Accumulation resumes from 0 when rst deasserts, provided opmode is unchanged.
- rst and ce asserted in the same cycle: reset wins.
- cep=0 while operands change: p and pcout hold.

Optional Feature:
DSP_POST_SAT_EN
- Defined: r is treated as signed 48-bit. On signed overflow, p clamps:
  - positive overflow -> 48'h7FFF_FFFF_FFFF
  - negative overflow -> 48'h8000_0000_0000
  - carryout is unchanged.
- Undefined: modulo-2^48 wrap, identical to the Spartan-6 primitive.

Decomposition:
- Package dsp_post_pkg:
  - opmode field positions (X_SEL, Z_SEL, CIN_BIT, SUB_BIT)
  - X/Z select enums: X_ZERO, X_M, X_P, X_DAB; Z_ZERO, Z_PCIN, Z_P, Z_C
  - width constants P_W=48, M_W=36
  - saturation limits
- One sub-module, dsp_pipe_reg (params REG, WIDTH; ports clk, rst, ce, d, q). Instantiated for OPMODE, CYI, P and CARRYOUT.

Test Plan:
1. PREG=1, opmode=0x0D (X=m, Z=c), m=5, c=100, cep=1 -> p=105 one cycle later; carryout=0.
2. Accumulate, opmode=0x09, m=3 for 4 cycles from reset -> p=3,6,9,12; then cep=0 -> p holds 12.
3. Subtract, opmode=0x8D, c=10, m=12 -> p=48'hFFFF_FFFF_FFFE; carryout=1 (borrow).
4. Carry-in, CARRYINSEL="OPMODE5", opmode=0x2F (X=dab, Z=c, cin=1), dab=48'hFFFF_FFFF_FFFF, c=0 -> p=0, carryout=1.
5. rst asserted on the third accumulate cycle with cep=1 -> p=0 next edge; accumulation restarts at 3.
6. DSP_POST_SAT_EN defined, opmode=0x0F, c=48'h7FFF_FFFF_FFFF, dab=1 -> p=48'h7FFF_FFFF_FFFF. Without the macro -> p=48'h8000_0000_0000.
